fll_ctrl_gen2: RTL and testbench

- Second-generation frequency-locked-loop trim controller for the ring-oscillator PLL test chip.
- Counts rising edges of a pre-divided oscillator signal over a programmable window of clk_ref cycles and compares the count against a lower/upper window.
- Steps a parametrised trim word with coarse-then-fine step sizes, qualified lock, saturation flags, settle delay and manual override.
- Single clock domain: the oscillator is sampled through a synchroniser, not used as a clock.

---
 rtl/fll_pkg.sv | 19 +
 rtl/fll_ctrl_gen2_if.sv | 25 ++
 rtl/fll_edge_counter.sv | 33 +++
 rtl/fll_ctrl_gen2.sv | 112 +++++++++++
 tb/tb_fll_ctrl_gen2.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fll_pkg.sv
// fll_pkg: shared types, defaults and trim clamp helper for the FLL trim controller
package fll_pkg;

    typedef enum logic [1:0] {IDLE, MEASURE, UPDATE, SETTLE} fll_state_e;

    localparam int SYNC_STAGES_DEF = 2;

    // Signed int arithmetic leaves headroom for trim +/- step at any legal trim width
    function automatic int clamp_step(input int base, input int step, input logic up,
                                      input int lo_lim, input int hi_lim,
                                      output logic sat_hi, output logic sat_lo);
        int v;
        v = up ? base + step : base - step;
        sat_hi = v > hi_lim;
        sat_lo = v < lo_lim;
        return sat_hi ? hi_lim : sat_lo ? lo_lim : v;
    endfunction

endpackage

// File: rtl/fll_ctrl_gen2_if.sv
// fll_ctrl_gen2_if: configuration, oscillator input and status bundle of the FLL trim controller
interface fll_ctrl_gen2_if #(parameter int N = 32, parameter int TW = 9);
    logic          enable;
    logic          osc_div;
    logic [N-1:0]  gate_time;
    logic [N-1:0]  lower_bound;
    logic [N-1:0]  upper_bound;
    logic [TW-1:0] step_coarse;
    logic [7:0]    settle_cycles;
    logic          manual_en;
    logic [TW-1:0] manual_trim;
    logic [TW-1:0] trim;
    logic [N-1:0]  meas_count;
    logic          strobe;
    logic          locked;
    logic          sat_hi;
    logic          sat_lo;

    modport master (output enable, osc_div, gate_time, lower_bound, upper_bound, step_coarse,
                    settle_cycles, manual_en, manual_trim,
                    input trim, meas_count, strobe, locked, sat_hi, sat_lo);
    modport slave  (input enable, osc_div, gate_time, lower_bound, upper_bound, step_coarse,
                    settle_cycles, manual_en, manual_trim,
                    output trim, meas_count, strobe, locked, sat_hi, sat_lo);
endinterface

// File: rtl/fll_edge_counter.sv
// fll_edge_counter: synchronises an asynchronous divided clock and counts its rising edges, saturating
module fll_edge_counter import fll_pkg::*; #(
    parameter int N           = 32,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic         clk_ref,
    input  logic         reset_n,
    input  logic         osc,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] count
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   rise;

    assign rise = sync[SYNC_STAGES-1] & ~hist;

    always_ff @(posedge clk_ref or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            hist  <= 1'b0;
            count <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], osc};
            hist <= sync[SYNC_STAGES-1];
            if (clr)
                count <= '0;
            else if (en && rise && count != '1)
                count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/fll_ctrl_gen2.sv
// fll_ctrl_gen2: measures the divided oscillator over a gate window and steps a trim word
// coarse-then-fine towards an edge-count window, with qualified lock, settle and manual override
module fll_ctrl_gen2 import fll_pkg::*; #(
    parameter int N           = 32,
    parameter int TW          = 9,
    parameter int TRIM_MIN    = 0,
    parameter int TRIM_MAX    = 2**TW - 1,
    parameter int TRIM_INIT   = 448,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input logic           clk_ref,
    input logic           reset_n,
    fll_ctrl_gen2_if.slave bus
);
    localparam int RW = $clog2(LOCK_CNT + 1);

    fll_state_e    state, state_nx;
    logic [N-1:0]  count, gcnt, glen;
    logic [7:0]    scnt, slen;
    logic [RW-1:0] run;
    logic [TW-1:0] step, trim_nx;
    logic          fine, run_ok, clr, upd, hi, lo, c_hi, c_lo;

    assign run_ok = bus.enable & ~bus.manual_en;

    fll_edge_counter #(.N(N), .SYNC_STAGES(SYNC_STAGES)) u_edge (
        .clk_ref (clk_ref),
        .reset_n (reset_n),
        .osc     (bus.osc_div),
        .clr     (clr),
        .en      (state == MEASURE),
        .count   (count)
    );

    always_ff @(posedge clk_ref or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = !run_ok          ? IDLE :
                   state == IDLE    ? MEASURE :
                   state == MEASURE ? (gcnt == glen - 1'b1 ? UPDATE : MEASURE) :
                   state == UPDATE  ? (trim_nx != bus.trim && bus.settle_cycles != 8'd0 ? SETTLE : MEASURE) :
                                      (scnt == slen - 1'b1 ? MEASURE : SETTLE);
    end

    always_comb begin
        clr     = state_nx == MEASURE && state != MEASURE;
        upd     = state == UPDATE && run_ok;
        step    = fine ? TW'(1) : (bus.step_coarse == '0 ? TW'(1) : bus.step_coarse);
        hi      = count > bus.upper_bound;
        lo      = !hi && count < bus.lower_bound;
        c_hi    = 1'b0;
        c_lo    = 1'b0;
        trim_nx = bus.trim;
        if (bus.manual_en)
            trim_nx = TW'(clamp_step(int'(bus.manual_trim), 0, 1'b1, TRIM_MIN, TRIM_MAX, c_hi, c_lo));
        else if (upd && (hi || lo))
            trim_nx = TW'(clamp_step(int'(bus.trim), int'(step), hi, TRIM_MIN, TRIM_MAX, c_hi, c_lo));
    end

    always_ff @(posedge clk_ref or negedge reset_n) begin
        if (!reset_n) begin
            bus.trim       <= TW'(TRIM_INIT);
            bus.meas_count <= '0;
            bus.strobe     <= 1'b0;
            bus.locked     <= 1'b0;
            bus.sat_hi     <= 1'b0;
            bus.sat_lo     <= 1'b0;
            fine           <= 1'b0;
            run            <= '0;
            gcnt           <= '0;
            glen           <= '0;
            scnt           <= '0;
            slen           <= '0;
        end else begin
            bus.trim   <= trim_nx;
            bus.strobe <= upd;
            gcnt       <= clr ? '0 : gcnt + 1'b1;
            scnt       <= state == UPDATE ? '0 : scnt + 1'b1;
            if (clr)
                glen <= bus.gate_time == '0 ? N'(1) : bus.gate_time;
            if (state == UPDATE)
                slen <= bus.settle_cycles;
            if (!run_ok) begin
                bus.locked <= 1'b0;
                fine       <= 1'b0;
                run        <= '0;
                if (bus.manual_en) begin
                    bus.sat_hi <= 1'b0;
                    bus.sat_lo <= 1'b0;
                end
            end else if (upd) begin
                bus.meas_count <= count;
                bus.sat_hi     <= c_hi;
                bus.sat_lo     <= c_lo;
                if (hi || lo) begin
                    run        <= '0;
                    bus.locked <= 1'b0;
                end else begin
                    run        <= run == RW'(LOCK_CNT) ? run : run + 1'b1;
                    bus.locked <= run >= RW'(LOCK_CNT - 1);
                    fine       <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fll_ctrl_gen2.sv
// tb_fll_ctrl_gen2: directed and randomized checks of the FLL trim controller against a
// window-level reference model computed from the recorded oscillator samples
module tb_fll_ctrl_gen2;
    localparam int N = 32, TW = 9, TMAX = 511, TINIT = 448, LOCK = 4, SS = 2;

    logic clk_ref = 1'b0;
    logic reset_n = 1'b0;

    fll_ctrl_gen2_if #(.N(N), .TW(TW)) bus ();
    fll_ctrl_gen2 #(.N(N), .TW(TW)) dut (.clk_ref(clk_ref), .reset_n(reset_n), .bus(bus));

    always #5 clk_ref = ~clk_ref;

    int cyc = 0, n_strobe = 0, n_chk = 0, n_fail = 0, exp_strobes = 0;
    bit osc_v [0:65535];
    int osc_mode = 0, osc_p = 4, osc_c = 0;
    int m_trim = TINIT, m_run = 0, m_meas = 0, ms = 0;
    bit m_fine = 0, m_lock = 0, m_shi = 0, m_slo = 0;

    always @(posedge clk_ref) begin
        cyc <= cyc + 1;
        if (bus.strobe === 1'b1) n_strobe <= n_strobe + 1;
    end

    // Oscillator stimulus; the value driven now is the one sampled at posedge cyc+1
    always @(negedge clk_ref) begin
        int p;
        p = osc_mode == 2 ? (m_trim - 300) / 12 : osc_p;
        p = p < 5 && osc_mode == 2 ? 5 : p;
        osc_c = osc_c + 1 >= p ? 0 : osc_c + 1;
        bus.osc_div = osc_mode != 0 && osc_c < p / 2;
        if (cyc + 1 < 65536) osc_v[cyc + 1] = bus.osc_div;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk_ref);
    endtask

    // Rising edges whose detection falls in cycles s..s+g-1
    function automatic int win_count(input int s, input int g);
        int c = 0;
        for (int p = s; p < s + g; p++)
            if (osc_v[p - SS + 1] && !osc_v[p - SS]) c++;
        return c;
    endfunction

    task automatic expect_window();
        int g, cnt, step, v, ts;
        bit hi, lo, changed;
        g  = bus.gate_time == 0 ? 1 : int'(bus.gate_time);
        ts = ms + g + 1;
        wait_cyc(ts - 1);
        check("strobe_early", bus.strobe, 0);
        wait_cyc(ts);
        check("strobe", bus.strobe, 1);
        check("strobe_total", n_strobe, exp_strobes);
        exp_strobes++;
        cnt  = win_count(ms, g);
        step = m_fine ? 1 : (bus.step_coarse == 0 ? 1 : int'(bus.step_coarse));
        hi   = cnt > int'(bus.upper_bound);
        lo   = !hi && cnt < int'(bus.lower_bound);
        v = m_trim; m_shi = 0; m_slo = 0;
        if (hi) begin v = m_trim + step; if (v > TMAX) begin v = TMAX; m_shi = 1; end end
        else if (lo) begin v = m_trim - step; if (v < 0) begin v = 0; m_slo = 1; end end
        if (hi || lo) begin
            m_run = 0; m_lock = 0;
        end else begin
            m_run = m_run < LOCK ? m_run + 1 : LOCK; m_lock = m_run >= LOCK; m_fine = 1;
        end
        changed = v != m_trim;
        m_trim = v; m_meas = cnt;
        check("meas_count", bus.meas_count, m_meas);
        check("trim", bus.trim, m_trim);
        check("locked", bus.locked, m_lock);
        check("sat_hi", bus.sat_hi, m_shi);
        check("sat_lo", bus.sat_lo, m_slo);
        ms = ts + ((changed && bus.settle_cycles > 0) ? int'(bus.settle_cycles) : 0);
    endtask

    task automatic start_en();
        bus.enable = 1'b1;
        ms = cyc + 1;
    endtask

    task automatic drop_en();
        bus.enable = 1'b0;
        m_lock = 0; m_fine = 0; m_run = 0;
        repeat (4) @(negedge clk_ref);
        check("locked_off", bus.locked, 0);
    endtask

    task automatic set_cfg(input int g, input int lb, input int ub, input int co, input int st);
        bus.gate_time = N'(g); bus.lower_bound = N'(lb); bus.upper_bound = N'(ub);
        bus.step_coarse = TW'(co); bus.settle_cycles = 8'(st);
    endtask

    initial begin
        bus.enable = 1'b0; bus.manual_en = 1'b0; bus.manual_trim = '0; bus.osc_div = 1'b0;
        set_cfg(100, 24, 26, 16, 0);
        repeat (3) @(negedge clk_ref);
        check("rst_trim", bus.trim, TINIT);
        check("rst_meas", bus.meas_count, 0);
        check("rst_strobe", bus.strobe, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_sat", {bus.sat_hi, bus.sat_lo}, 0);
        reset_n = 1'b1;
        osc_mode = 1; osc_p = 4;
        repeat (8) @(negedge clk_ref);

        // In-window loop: trim holds, lock after LOCK windows
        start_en();
        repeat (6) expect_window();

        // enable dropped mid-window: discarded, state held, then restart latency
        wait_cyc(ms + 50);
        bus.enable = 1'b0; m_lock = 0; m_fine = 0; m_run = 0;
        wait_cyc(cyc + 150);
        check("drop_strobes", n_strobe, exp_strobes);
        check("drop_meas", bus.meas_count, m_meas);
        check("drop_trim", bus.trim, m_trim);
        check("drop_locked", bus.locked, 0);
        start_en();
        expect_window();

        // Count above window: coarse steps up to the TRIM_MAX clamp
        drop_en();
        set_cfg(100, 10, 12, 16, 3);
        start_en();
        repeat (5) expect_window();

        // Count below window with a huge step: clamp at TRIM_MIN
        drop_en();
        set_cfg(100, 40, 42, 200, 0);
        start_en();
        repeat (4) expect_window();

        // Manual override mid-window
        wait_cyc(ms + 20);
        bus.manual_trim = 9'd448; bus.manual_en = 1'b1;
        @(negedge clk_ref);
        m_trim = 448; m_lock = 0; m_fine = 0; m_run = 0; m_shi = 0; m_slo = 0;
        check("man_trim", bus.trim, 448);
        check("man_locked", bus.locked, 0);
        check("man_sat", {bus.sat_hi, bus.sat_lo}, 0);
        wait_cyc(cyc + 120);
        check("man_strobes", n_strobe, exp_strobes);
        check("man_hold", bus.trim, 448);

        // Release into a loop whose oscillator period tracks the trim word
        set_cfg(100, 10, 12, 8, 2);
        osc_mode = 2;
        bus.manual_en = 1'b0;
        ms = cyc + 1;
        repeat (12) expect_window();

        // Randomized configurations
        osc_mode = 1;
        for (int k = 0; k < 6; k++) begin
            drop_en();
            set_cfg(k == 0 ? 0 : int'($urandom_range(1, 60)), int'($urandom_range(0, 14)),
                    int'($urandom_range(0, 14)), int'($urandom_range(0, 40)), int'($urandom_range(0, 6)));
            osc_p = int'($urandom_range(5, 12));
            repeat (4) @(negedge clk_ref);
            start_en();
            repeat (4) expect_window();
        end

        // Asynchronous reset in the first SETTLE cycle, while strobe is high
        drop_en();
        bus.manual_trim = 9'd300; bus.manual_en = 1'b1;
        @(negedge clk_ref);
        bus.manual_en = 1'b0;
        m_trim = 300; m_shi = 0; m_slo = 0;
        set_cfg(100, 40, 42, 16, 40);
        osc_p = 4;
        repeat (4) @(negedge clk_ref);
        start_en();
        expect_window();
        #2 reset_n = 1'b0;
        #1;
        check("arst_trim", bus.trim, TINIT);
        check("arst_meas", bus.meas_count, 0);
        check("arst_strobe", bus.strobe, 0);
        check("arst_locked", bus.locked, 0);
        check("arst_sat", {bus.sat_hi, bus.sat_lo}, 0);
        @(negedge clk_ref);
        bus.enable = 1'b0;
        exp_strobes--;
        m_trim = TINIT; m_meas = 0; m_run = 0; m_fine = 0; m_lock = 0; m_shi = 0; m_slo = 0;
        repeat (2) @(negedge clk_ref);
        reset_n = 1'b1;
        repeat (6) @(negedge clk_ref);
        set_cfg(100, 24, 26, 16, 0);
        start_en();
        repeat (2) expect_window();
        wait_cyc(cyc + 5);
        check("final_strobes", n_strobe, exp_strobes);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
